tap_ctrl: RTL

//  IEEE 1149.1 TAP controller that sequences the IDCODE shift register and an internal BYPASS bit.

---
 rtl/tap_ctrl_if.sv | 26 ++
 rtl/tap_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/tap_ctrl_if.sv
// JTAG pin and ID-register bundle for the TAP controller.
// The slave side belongs to tap_ctrl; the master side drives the pins and models the ID register.
interface tap_ctrl_if #(
  parameter int IR_W = 6
);
  logic            TMS;
  logic            TDI;
  logic            TDO;
  logic            TDO_en;
  logic            ID_Shift_in;
  logic            ID_Shift_out;
  logic            ID_Shift_DR;
  logic            ID_clk_en;
  logic [3:0]      tap_state;
  logic [IR_W-1:0] ir_q;

  modport master (
    output TMS, TDI, ID_Shift_out,
    input  TDO, TDO_en, ID_Shift_in, ID_Shift_DR, ID_clk_en, tap_state, ir_q
  );

  modport slave (
    input  TMS, TDI, ID_Shift_out,
    output TDO, TDO_en, ID_Shift_in, ID_Shift_DR, ID_clk_en, tap_state, ir_q
  );
endinterface

// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register, BYPASS bit
// and TDO steering between the IR, BYPASS and the external IDCODE register.
module tap_ctrl #(
  parameter int              IR_W      = 6,
  parameter logic [IR_W-1:0] IDCODE_OP = 6'b001001,
  parameter logic [IR_W-1:0] BYPASS_OP = 6'b111111,
  parameter logic [IR_W-1:0] IR_CAPT   = 6'b000001
) (
  input  logic       t_clk,
  input  logic       t_rst,
  tap_ctrl_if.slave  jtag
);

  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_PAUDR = 4'h3;
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_PAUIR = 4'hB;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_UPDIR = 4'hD;

  logic [3:0]      state;
  logic [3:0]      next_state;
  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] ir_sr;
  logic            bypass_q;
  logic            id_sel;
  logic            bypass_sel;
  logic            tms;

  assign tms = jtag.TMS;

  always_comb begin
    next_state = ST_TLR;
    case (state)
      ST_TLR:   next_state = tms ? ST_TLR   : ST_RTI;
      ST_RTI:   next_state = tms ? ST_SELDR : ST_RTI;
      ST_SELDR: next_state = tms ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: next_state = tms ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  next_state = tms ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: next_state = tms ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: next_state = tms ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: next_state = tms ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: next_state = tms ? ST_SELDR : ST_RTI;
      ST_SELIR: next_state = tms ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: next_state = tms ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  next_state = tms ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: next_state = tms ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: next_state = tms ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: next_state = tms ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: next_state = tms ? ST_SELDR : ST_RTI;
      default:  next_state = ST_TLR;
    endcase
  end

  // Undefined opcodes fold onto BYPASS, so only IDCODE selects the external chain.
  assign id_sel     = (ir_q == IDCODE_OP);
  assign bypass_sel = (ir_q == BYPASS_OP) || !id_sel;

  always_ff @(posedge t_clk) begin
    if (t_rst) begin
      state    <= ST_TLR;
      ir_q     <= IDCODE_OP;
      ir_sr    <= '0;
      bypass_q <= 1'b0;
    end else begin
      state <= next_state;

      if (state == ST_CAPIR)
        ir_sr <= IR_CAPT;
      else if (state == ST_SHIR)
        ir_sr <= {jtag.TDI, ir_sr[IR_W-1:1]};

      // Any path into (or loop on) Test-Logic-Reset restores IDCODE as the active instruction.
      if (next_state == ST_TLR)
        ir_q <= IDCODE_OP;
      else if (state == ST_UPDIR)
        ir_q <= ir_sr;

      if (bypass_sel) begin
        if (state == ST_CAPDR)
          bypass_q <= 1'b0;
        else if (state == ST_SHDR)
          bypass_q <= jtag.TDI;
      end
    end
  end

  always_comb begin
    jtag.TDO = 1'b0;
    if (state == ST_SHIR)
      jtag.TDO = ir_sr[0];
    else if (state == ST_SHDR)
      jtag.TDO = id_sel ? jtag.ID_Shift_out : bypass_q;
  end

  assign jtag.TDO_en      = (state == ST_SHDR) || (state == ST_SHIR);
  assign jtag.ID_Shift_in = jtag.TDI;
  assign jtag.ID_Shift_DR = (state == ST_SHDR);
  assign jtag.ID_clk_en   = ((state == ST_CAPDR) || (state == ST_SHDR)) && id_sel;
  assign jtag.tap_state   = state;
  assign jtag.ir_q        = ir_q;

endmodule
